cla_share_arbiter: RTL and testbench

Shares one instance of the team's 4-bit carry-lookahead adder (carry_lookahead_adder_4_bit) between NUM_REQ requesters. Each requester offers an operand pair with a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the 5-bit sum is captured in a single registered output stage tagged with the requester ID. The block sits between requester-side logic (e.g. sensor/threshold units) and a single consumer of sums.

---
 rtl/cla_arb_pkg.sv | 15 +
 rtl/carry_lookahead_adder_4_bit.sv | 24 ++
 rtl/cla_share_arbiter_rr_arbiter.sv | 37 +++
 rtl/cla_share_arbiter.sv | 91 +++++++++
 tb/tb_cla_share_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_arb_pkg.sv
// cla_arb_pkg: shared constants and helpers for the CLA share arbiter
package cla_arb_pkg;
    localparam int OPD_W       = 4;
    localparam int RES_W       = 5;
    localparam int DEF_NUM_REQ = 4;

    // Smallest w with 2**w >= n; used to validate the ID width
    function automatic int id_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction
endpackage

// File: rtl/carry_lookahead_adder_4_bit.sv
// carry_lookahead_adder_4_bit: 4-bit adder with explicit lookahead carries
module carry_lookahead_adder_4_bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    // Generate/propagate terms expanded into flat carry equations
    always_comb begin
        g = i_a & i_b;
        p = i_a ^ i_b;
        c[0] = i_cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        o_sum = p ^ c[3:0];
        o_cout = c[4];
    end
endmodule

// File: rtl/cla_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a rotating priority pointer
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic          advance,
    input  logic [IW-1:0] advance_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr_q, ptr_d;
    // Scan farthest-to-nearest from the pointer so the nearest requester wins
    always_comb begin
        int j;
        gnt = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (enable && req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        ptr_d = !advance ? ptr_q : (int'(advance_idx) == N - 1) ? '0 : advance_idx + 1'b1;
    end
    // Pointer moves only on an accepted transfer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/cla_share_arbiter.sv
// cla_share_arbiter: round-robin sharing of one 4-bit CLA; optional CLA_ARB_STATS_EN adds o_carry_cnt
module cla_share_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [OPD_W*NUM_REQ-1:0] i_req_a,
    input  logic [OPD_W*NUM_REQ-1:0] i_req_b,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_rsp_valid,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [RES_W-1:0]         o_rsp_result,
`ifdef CLA_ARB_STATS_EN
    output logic [7:0]               o_carry_cnt,
`endif
    input  logic                     i_rsp_ready
);
    if (ID_W < id_width(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W too small for NUM_REQ");
    end

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx, rsp_id_q, rsp_id_d;
    logic [OPD_W-1:0]   a_sel, b_sel, sum;
    logic               cout, transfer, can_accept, rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]   rsp_result_q, rsp_result_d;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .req        (i_req_valid),
        .enable     (i_rst_n & can_accept),
        .advance    (transfer),
        .advance_idx(gnt_idx),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    carry_lookahead_adder_4_bit u_add (
        .i_a   (a_sel),
        .i_b   (b_sel),
        .i_cin (1'b0),
        .o_sum (sum),
        .o_cout(cout)
    );

    // Operand mux and next-state of the single output slot (refill beats drain)
    always_comb begin
        can_accept = !rsp_valid_q | i_rsp_ready;
        transfer = |gnt;
        a_sel = i_req_a[int'(gnt_idx)*OPD_W +: OPD_W];
        b_sel = i_req_b[int'(gnt_idx)*OPD_W +: OPD_W];
        rsp_valid_d = transfer ? 1'b1 : i_rsp_ready ? 1'b0 : rsp_valid_q;
        rsp_result_d = transfer ? {cout, sum} : rsp_result_q;
        rsp_id_d = transfer ? gnt_idx : rsp_id_q;
    end

    // Result register; reset discards any held result
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign o_req_ready = gnt;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id = rsp_id_q;
    assign o_rsp_result = rsp_result_q;

`ifdef CLA_ARB_STATS_EN
    logic [7:0] carry_cnt_q, carry_cnt_d;
    // Saturating count of carry-producing transfers
    always_comb carry_cnt_d = (transfer && cout && carry_cnt_q != 8'hFF) ? carry_cnt_q + 8'd1 : carry_cnt_q;
    // Counter register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) carry_cnt_q <= '0;
        else carry_cnt_q <= carry_cnt_d;
    end
    assign o_carry_cnt = carry_cnt_q;
`endif
endmodule

// File: tb/tb_cla_share_arbiter.sv
// tb_cla_share_arbiter: directed and randomized checks of cla_share_arbiter
module tb_cla_share_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  i_req_valid;
    logic [15:0] i_req_a, i_req_b;
    logic [3:0]  o_req_ready;
    logic        o_rsp_valid;
    logic [1:0]  o_rsp_id;
    logic [4:0]  o_rsp_result;
    logic        i_rsp_ready;
`ifdef CLA_ARB_STATS_EN
    logic [7:0]  o_carry_cnt;
`endif
    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    cla_share_arbiter dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_result(o_rsp_result),
`ifdef CLA_ARB_STATS_EN
        .o_carry_cnt (o_carry_cnt),
`endif
        .i_rsp_ready (i_rsp_ready)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ops(input int k, input int a, input int b);
        i_req_a[4*k +: 4] = 4'(a);
        i_req_b[4*k +: 4] = 4'(b);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = 1'b0;
        i_req_a = '0;
        i_req_b = '0;
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_req_valid = 4'hF;
        i_rsp_ready = 1'b1;
        i_req_a = '1;
        i_req_b = '1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", o_req_ready); end
        tick();
        checks++;
        if (o_rsp_valid !== 1'b0 || o_rsp_id !== 2'd0 || o_rsp_result !== 5'd0) begin
            failures++; $display("FAIL reset_state got v=%b id=%0d r=%h exp 0/0/0", o_rsp_valid, o_rsp_id, o_rsp_result);
        end
        i_req_valid = '0;
        i_rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_ops(0, 7, 9);
        i_req_valid = 4'b0001;
        i_rsp_ready = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", o_req_ready); end
        tick();
        i_req_valid = '0;
        checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_result !== 5'h10) begin
            failures++; $display("FAIL single_result got v=%b id=%0d r=%h exp 1/0/10", o_rsp_valid, o_rsp_id, o_rsp_result);
        end
        tick();
        checks++;
        if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", o_rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) set_ops(k, k, 1);
        i_req_valid = 4'hF;
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (o_req_ready !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, o_req_ready, 4'(1 << (i % 4))); end
            tick();
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'(i % 4) || o_rsp_result !== 5'(i % 4 + 1)) begin
                failures++; $display("FAIL rr_result%0d got v=%b id=%0d r=%0d exp 1/%0d/%0d", i, o_rsp_valid, o_rsp_id, o_rsp_result, i % 4, i % 4 + 1);
            end
        end
        i_req_valid = '0;
    endtask

    task automatic test_hold();
        do_reset();
        set_ops(0, 2, 3);
        set_ops(1, 1, 1);
        set_ops(2, 2, 2);
        i_req_valid = 4'b0001;
        i_rsp_ready = 1'b1;
        tick();
        i_req_valid = 4'b0110;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o_req_ready !== 4'b0000) begin failures++; $display("FAIL hold_ready%0d got=%b exp=0000", i, o_req_ready); end
            tick();
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_result !== 5'd5) begin
                failures++; $display("FAIL hold_stable%0d got v=%b id=%0d r=%0d exp 1/0/5", i, o_rsp_valid, o_rsp_id, o_rsp_result);
            end
        end
        i_rsp_ready = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0010) begin failures++; $display("FAIL hold_release got=%b exp=0010", o_req_ready); end
        tick();
        checks++;
        if (o_rsp_id !== 2'd1 || o_rsp_result !== 5'd2) begin failures++; $display("FAIL hold_r1 got id=%0d r=%0d exp 1/2", o_rsp_id, o_rsp_result); end
        checks++;
        if (o_req_ready !== 4'b0100) begin failures++; $display("FAIL hold_next got=%b exp=0100", o_req_ready); end
        tick();
        checks++;
        if (o_rsp_id !== 2'd2 || o_rsp_result !== 5'd4) begin failures++; $display("FAIL hold_r2 got id=%0d r=%0d exp 2/4", o_rsp_id, o_rsp_result); end
        i_req_valid = '0;
    endtask

    task automatic test_boundaries();
        int tab [3][3] = '{'{15, 15, 30}, '{0, 0, 0}, '{8, 8, 16}};
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ops(0, tab[i][0], tab[i][1]);
            i_req_valid = 4'b0001;
            tick();
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_result !== 5'(tab[i][2])) begin
                failures++; $display("FAIL boundary%0d got v=%b r=%b exp 1/%b", i, o_rsp_valid, o_rsp_result, 5'(tab[i][2]));
            end
        end
        i_req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ops(1, 1, 2);
        set_ops(3, 3, 3);
        set_ops(0, 4, 4);
        i_req_valid = 4'b0010;
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        i_req_valid = 4'b1000;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_req_ready !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b exp=0000", o_req_ready); end
        tick();
        checks++;
        if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", o_rsp_valid); end
        i_rst_n = 1'b1;
        i_req_valid = 4'b1001;
        i_rsp_ready = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%b exp=0001", o_req_ready); end
        tick();
        checks++;
        if (o_rsp_id !== 2'd0 || o_rsp_result !== 5'd8) begin failures++; $display("FAIL midrst_res got id=%0d r=%0d exp 0/8", o_rsp_id, o_rsp_result); end
        i_req_valid = '0;
    endtask

    task automatic test_random();
        int mptr, mid, mres, eg, k;
        bit mvalid;
        logic [3:0] exp_rdy;
        do_reset();
        mptr = 0; mid = 0; mres = 0; mvalid = 0;
        for (int c = 0; c < 500; c++) begin
            i_req_valid = 4'($urandom_range(0, 15));
            i_req_a = 16'($urandom);
            i_req_b = 16'($urandom);
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = -1;
            if (!mvalid || i_rsp_ready)
                for (int i = 0; i < 4; i++) begin
                    k = (mptr + i) % 4;
                    if (eg < 0 && i_req_valid[k]) eg = k;
                end
            exp_rdy = (eg >= 0) ? 4'(1 << eg) : 4'b0000;
            checks++;
            if (o_req_ready !== exp_rdy) begin failures++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, o_req_ready, exp_rdy); end
            if (eg >= 0) begin
                mres = int'(i_req_a[4*eg +: 4]) + int'(i_req_b[4*eg +: 4]);
                mid = eg;
                mvalid = 1;
                mptr = (eg + 1) % 4;
            end else if (i_rsp_ready) mvalid = 0;
            tick();
            checks++;
            if (o_rsp_valid !== mvalid || o_rsp_id !== 2'(mid) || o_rsp_result !== 5'(mres)) begin
                failures++; $display("FAIL rand_out c=%0d got v=%b id=%0d r=%0d exp %b/%0d/%0d", c, o_rsp_valid, o_rsp_id, o_rsp_result, mvalid, mid, mres);
            end
        end
        i_req_valid = '0;
    endtask

`ifdef CLA_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (o_carry_cnt !== 8'd0) begin failures++; $display("FAIL stats_init got=%0d exp=0", o_carry_cnt); end
        set_ops(0, 15, 1);
        i_req_valid = 4'b0001;
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        checks++;
        if (o_carry_cnt !== 8'd255) begin failures++; $display("FAIL stats_sat got=%0d exp=255", o_carry_cnt); end
        set_ops(0, 3, 4);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (o_carry_cnt !== 8'd255) begin failures++; $display("FAIL stats_nocarry got=%0d exp=255", o_carry_cnt); end
        do_reset();
        checks++;
        if (o_carry_cnt !== 8'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", o_carry_cnt); end
    endtask
`endif

    initial begin
        i_rst_n = 1'b0;
        i_req_valid = '0;
        i_req_a = '0;
        i_req_b = '0;
        i_rsp_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_boundaries();
        test_reset_mid();
        test_random();
`ifdef CLA_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
